// File: rtl/ace_snoop_responder_if.sv
// Signal bundle between the ACE snoop responder and its environment: AC/CR/CD snoop
// channels plus the cache-state lookup, line-read and state-update sideband.
interface ace_snoop_responder_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 128,
  parameter int BeatWidth = 2
);
  logic                 ac_valid_i;
  logic                 ac_ready_o;
  logic [AddrWidth-1:0] ac_addr_i;
  logic [3:0]           ac_snoop_i;
  logic [2:0]           ac_prot_i;
  logic                 cr_valid_o;
  logic                 cr_ready_i;
  logic [4:0]           cr_resp_o;
  logic                 cd_valid_o;
  logic                 cd_ready_i;
  logic [DataWidth-1:0] cd_data_o;
  logic                 cd_last_o;
  logic                 lu_req_o;
  logic [AddrWidth-1:0] lu_addr_o;
  logic                 lu_gnt_i;
  logic                 lu_hit_i;
  logic                 lu_dirty_i;
  logic                 lu_unique_i;
  logic                 rd_req_o;
  logic [BeatWidth-1:0] rd_beat_o;
  logic                 rd_gnt_i;
  logic [DataWidth-1:0] rd_data_i;
  logic                 upd_valid_o;
  logic                 upd_inval_o;
  logic                 upd_clean_o;
  logic                 upd_shared_o;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
           lu_gnt_i, lu_hit_i, lu_dirty_i, lu_unique_i, rd_gnt_i, rd_data_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_req_o, lu_addr_o, rd_req_o, rd_beat_o,
           upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
           lu_gnt_i, lu_hit_i, lu_dirty_i, lu_unique_i, rd_gnt_i, rd_data_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_req_o, lu_addr_o, rd_req_o, rd_beat_o,
           upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
  );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: looks up the line, answers on CR, streams the line on CD when data moves
// and pulses a state update on the CR handshake. Perf counters enabled by ACE_SNOOP_RESP_PERF_EN.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 128,
  parameter int LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ace_snoop_responder_if.slave bus
`ifdef ACE_SNOOP_RESP_PERF_EN
  ,
  output logic [31:0]          perf_snoops_o,
  output logic [31:0]          perf_hits_o,
  output logic [31:0]          perf_data_o
`endif
);
  localparam int CdBeats   = LineWidth / DataWidth;
  localparam int BeatWidth = (CdBeats > 1) ? $clog2(CdBeats) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(CdBeats - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_RDREQ, S_RDWAIT, S_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  logic [2:0]           prot_q, prot_d;
  logic [4:0]           cr_resp_q, cr_resp_d;
  logic                 upd_req_q, upd_req_d;
  logic                 upd_inval_q, upd_inval_d;
  logic                 upd_clean_q, upd_clean_d;
  logic                 upd_shared_q, upd_shared_d;
  logic [BeatWidth-1:0] beat_q, beat_d;
  logic [DataWidth-1:0] cd_data_q, cd_data_d;
  logic                 cd_last_q, cd_last_d;

  logic [4:0] resp_s;
  logic       inval_s, clean_s, shared_s;
  logic       ac_ready_s, cr_valid_s, cd_valid_s, lu_req_s, rd_req_s, upd_valid_s;
  logic       unused_prot_s;

  assign unused_prot_s = ^prot_q;

  // Response table; resp is {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  always_comb begin
    resp_s   = 5'b0_0000;
    inval_s  = 1'b0;
    clean_s  = 1'b0;
    shared_s = 1'b0;
    if (bus.lu_hit_i) begin
      case (snoop_q)
        4'b0000: resp_s = {bus.lu_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
        4'b0001, 4'b0010, 4'b0011: begin
          resp_s   = {bus.lu_unique_i, 1'b1, bus.lu_dirty_i, 1'b0, 1'b1};
          shared_s = 1'b1;
          clean_s  = bus.lu_dirty_i;
        end
        4'b0111: begin
          resp_s  = {bus.lu_unique_i, 1'b0, bus.lu_dirty_i, 1'b0, 1'b1};
          inval_s = 1'b1;
        end
        4'b1001: begin
          resp_s  = {bus.lu_unique_i, 1'b0, bus.lu_dirty_i, 1'b0, bus.lu_dirty_i};
          inval_s = 1'b1;
        end
        4'b1000: begin
          resp_s  = {bus.lu_unique_i, 1'b1, bus.lu_dirty_i, 1'b0, bus.lu_dirty_i};
          clean_s = bus.lu_dirty_i;
        end
        4'b1101: begin
          resp_s  = {bus.lu_unique_i, 4'b0000};
          inval_s = 1'b1;
        end
        default: resp_s = 5'b0_0000;
      endcase
    end else begin
      resp_s = 5'b0_0000;
    end
  end

  // Next state, capture registers and state-decoded handshake outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    snoop_d      = snoop_q;
    prot_d       = prot_q;
    cr_resp_d    = cr_resp_q;
    upd_req_d    = upd_req_q;
    upd_inval_d  = upd_inval_q;
    upd_clean_d  = upd_clean_q;
    upd_shared_d = upd_shared_q;
    beat_d       = beat_q;
    cd_data_d    = cd_data_q;
    cd_last_d    = cd_last_q;
    ac_ready_s   = 1'b0;
    cr_valid_s   = 1'b0;
    cd_valid_s   = 1'b0;
    lu_req_s     = 1'b0;
    rd_req_s     = 1'b0;
    upd_valid_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ac_ready_s = 1'b1;
        if (bus.ac_valid_i) begin
          addr_d  = bus.ac_addr_i;
          snoop_d = bus.ac_snoop_i;
          prot_d  = bus.ac_prot_i;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        lu_req_s = 1'b1;
        state_d  = bus.lu_gnt_i ? S_WAIT : S_LOOKUP;
      end
      S_WAIT: begin
        cr_resp_d    = resp_s;
        upd_req_d    = inval_s | clean_s | shared_s;
        upd_inval_d  = inval_s;
        upd_clean_d  = clean_s;
        upd_shared_d = shared_s;
        state_d      = S_RESP;
      end
      S_RESP: begin
        cr_valid_s = 1'b1;
        if (bus.cr_ready_i) begin
          upd_valid_s = upd_req_q;
          state_d     = cr_resp_q[0] ? S_RDREQ : S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RDREQ: begin
        rd_req_s = 1'b1;
        state_d  = bus.rd_gnt_i ? S_RDWAIT : S_RDREQ;
      end
      S_RDWAIT: begin
        cd_data_d = bus.rd_data_i;
        cd_last_d = (beat_q == LastBeat);
        state_d   = S_DATA;
      end
      S_DATA: begin
        cd_valid_s = 1'b1;
        if (bus.cd_ready_i && cd_last_q) begin
          beat_d  = {BeatWidth{1'b0}};
          state_d = S_IDLE;
        end else if (bus.cd_ready_i) begin
          beat_d  = beat_q + BeatWidth'(1);
          state_d = S_RDREQ;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= {AddrWidth{1'b0}};
      snoop_q      <= 4'b0000;
      prot_q       <= 3'b000;
      cr_resp_q    <= 5'b0_0000;
      upd_req_q    <= 1'b0;
      upd_inval_q  <= 1'b0;
      upd_clean_q  <= 1'b0;
      upd_shared_q <= 1'b0;
      beat_q       <= {BeatWidth{1'b0}};
      cd_data_q    <= {DataWidth{1'b0}};
      cd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      snoop_q      <= snoop_d;
      prot_q       <= prot_d;
      cr_resp_q    <= cr_resp_d;
      upd_req_q    <= upd_req_d;
      upd_inval_q  <= upd_inval_d;
      upd_clean_q  <= upd_clean_d;
      upd_shared_q <= upd_shared_d;
      beat_q       <= beat_d;
      cd_data_q    <= cd_data_d;
      cd_last_q    <= cd_last_d;
    end
  end

  assign bus.ac_ready_o   = ac_ready_s;
  assign bus.cr_valid_o   = cr_valid_s;
  assign bus.cr_resp_o    = cr_resp_q;
  assign bus.cd_valid_o   = cd_valid_s;
  assign bus.cd_data_o    = cd_data_q;
  assign bus.cd_last_o    = cd_last_q;
  assign bus.lu_req_o     = lu_req_s;
  assign bus.lu_addr_o    = addr_q;
  assign bus.rd_req_o     = rd_req_s;
  assign bus.rd_beat_o    = beat_q;
  assign bus.upd_valid_o  = upd_valid_s;
  assign bus.upd_inval_o  = upd_valid_s & upd_inval_q;
  assign bus.upd_clean_o  = upd_valid_s & upd_clean_q;
  assign bus.upd_shared_o = upd_valid_s & upd_shared_q;

`ifdef ACE_SNOOP_RESP_PERF_EN
  logic [31:0] perf_snoops_q, perf_snoops_d;
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_data_q, perf_data_d;

  // Saturating event counters.
  always_comb begin
    perf_snoops_d = perf_snoops_q;
    perf_hits_d   = perf_hits_q;
    perf_data_d   = perf_data_q;
    if ((state_q == S_IDLE) && bus.ac_valid_i && (perf_snoops_q != 32'hFFFF_FFFF)) begin
      perf_snoops_d = perf_snoops_q + 32'd1;
    end else begin
      perf_snoops_d = perf_snoops_q;
    end
    if ((state_q == S_WAIT) && bus.lu_hit_i && (perf_hits_q != 32'hFFFF_FFFF)) begin
      perf_hits_d = perf_hits_q + 32'd1;
    end else begin
      perf_hits_d = perf_hits_q;
    end
    if ((state_q == S_RESP) && bus.cr_ready_i && cr_resp_q[0] && (perf_data_q != 32'hFFFF_FFFF)) begin
      perf_data_d = perf_data_q + 32'd1;
    end else begin
      perf_data_d = perf_data_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_snoops_q <= 32'd0;
      perf_hits_q   <= 32'd0;
      perf_data_q   <= 32'd0;
    end else begin
      perf_snoops_q <= perf_snoops_d;
      perf_hits_q   <= perf_hits_d;
      perf_data_q   <= perf_data_d;
    end
  end

  assign perf_snoops_o = perf_snoops_q;
  assign perf_hits_o   = perf_hits_q;
  assign perf_data_o   = perf_data_q;
`endif
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed scenarios then randomized snoops,
// checked against a line-state reference model kept in the bench.
module tb_ace_snoop_responder;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int LW = 512;
  localparam int NB = LW / DW;
  localparam int BW = 2;
  localparam int NL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ace_snoop_responder_if #(.AddrWidth(AW), .DataWidth(DW), .BeatWidth(BW)) bus ();
`ifdef ACE_SNOOP_RESP_PERF_EN
  logic [31:0] perf_snoops, perf_hits, perf_data;
`endif

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ACE_SNOOP_RESP_PERF_EN
    ,
    .perf_snoops_o (perf_snoops),
    .perf_hits_o   (perf_hits),
    .perf_data_o   (perf_data)
`endif
  );

  bit          m_hit[NL], m_dirty[NL], m_uniq[NL];
  logic [DW-1:0] m_data[NL][NB];
  int          m_snoops, m_hits, m_xfers;
  int          compared = 0;
  int          mismatched = 0;
  logic [3:0]  codes[10];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the snooped cache hands over and what it keeps, by transaction kind.
  function automatic void ref_model(input logic [3:0] sn, input bit h, input bit d, input bit u,
                                    output logic [4:0] resp, output bit upd,
                                    output bit inv, output bit cln, output bit shr);
    bit known, reader, once, cleaner, retains, dt, pd;
    known = 1'b1; reader = 1'b0; once = 1'b0; cleaner = 1'b0; retains = 1'b0;
    case (sn)
      4'b0000: begin reader = 1'b1; once = 1'b1; retains = 1'b1; end
      4'b0001, 4'b0010, 4'b0011: begin reader = 1'b1; retains = 1'b1; end
      4'b0111: reader = 1'b1;
      4'b1001: cleaner = 1'b1;
      4'b1000: begin cleaner = 1'b1; retains = 1'b1; end
      4'b1101: known = 1'b1;
      default: known = 1'b0;
    endcase
    if (!(known && h)) begin
      resp = 5'd0; upd = 1'b0; inv = 1'b0; cln = 1'b0; shr = 1'b0;
      return;
    end
    dt   = reader || (cleaner && d);
    pd   = d && dt && !once;
    inv  = !retains;
    shr  = retains && reader && !once;
    cln  = retains && pd;
    upd  = inv || shr || cln;
    resp = {u, retains, pd, 1'b0, dt};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 128'({bus.ac_ready_o, bus.cr_valid_o, bus.cr_resp_o, bus.cd_valid_o,
                               bus.cd_last_o, bus.lu_req_o, bus.rd_req_o, bus.rd_beat_o,
                               bus.upd_valid_o, bus.upd_inval_o, bus.upd_clean_o, bus.upd_shared_o}),
          128'({1'b1, 16'd0}));
    check({tag, "_data"}, 128'(bus.cd_data_o), 128'(0));
    check({tag, "_addr"}, 128'(bus.lu_addr_o), 128'(0));
`ifdef ACE_SNOOP_RESP_PERF_EN
    check({tag, "_perf"}, 128'({perf_snoops, perf_hits, perf_data}), 128'(0));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    m_snoops = 0; m_hits = 0; m_xfers = 0;
  endtask

  task automatic run_snoop(input int idx, input logic [3:0] sn, input int cr_stall,
                           input int cd_stall, input bit rnd_bp, input int rst_beat);
    logic [AW-1:0] addr;
    logic [4:0]    exp_resp, held_resp;
    logic [DW-1:0] held_data, exp_data;
    bit h, d, u, e_upd, e_inv, e_cln, e_shr;
    bit lu_pend, cr_done, cr_seen, cr_held, cd_held, held_last, done, aborted;
    int rd_pend, nbeats, nupd, ncr, cr_wait, cd_wait, exp_beats;
    h = m_hit[idx]; d = m_dirty[idx]; u = m_uniq[idx];
    ref_model(sn, h, d, u, exp_resp, e_upd, e_inv, e_cln, e_shr);
    exp_beats = exp_resp[0] ? NB : 0;
    addr = {$urandom(), $urandom()};
    addr[5:0] = 6'd0;
    lu_pend = 1'b0; cr_done = 1'b0; cr_seen = 1'b0; cr_held = 1'b0; cd_held = 1'b0;
    held_last = 1'b0; done = 1'b0; aborted = 1'b0; held_resp = 5'd0; held_data = '0;
    rd_pend = -1; nbeats = 0; nupd = 0; ncr = 0; cr_wait = 0; cd_wait = 0;

    bus.ac_valid_i = 1'b1; bus.ac_addr_i = addr; bus.ac_snoop_i = sn; bus.ac_prot_i = 3'($urandom());
    #1;
    check("ac_ready_idle", 128'(bus.ac_ready_o), 128'(1));
    @(posedge clk); #1;
    bus.ac_valid_i = 1'b0; bus.ac_snoop_i = 4'($urandom()); bus.ac_addr_i = {$urandom(), $urandom()};
    m_snoops++;

    for (int k = 1; k <= 300; k++) begin
      if (rst_beat >= 0 && bus.cd_valid_o && nbeats == rst_beat) begin
        rst = 1'b1; bus.cd_ready_i = 1'b0;
        @(posedge clk); #1;
        m_snoops = 0; m_hits = 0; m_xfers = 0;
        check_idle_outputs("midreset");
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      {bus.lu_hit_i, bus.lu_dirty_i, bus.lu_unique_i} = lu_pend ? {h, d, u} : 3'($urandom());
      bus.rd_data_i = (rd_pend >= 0) ? m_data[idx][rd_pend] : {$urandom(), $urandom(), $urandom(), $urandom()};
      lu_pend = 1'b0; rd_pend = -1;
      bus.lu_gnt_i   = rnd_bp ? 1'($urandom()) : 1'b1;
      bus.rd_gnt_i   = rnd_bp ? 1'($urandom()) : 1'b1;
      bus.cr_ready_i = rnd_bp ? 1'($urandom()) : (cr_wait >= cr_stall);
      bus.cd_ready_i = rnd_bp ? 1'($urandom()) : !(nbeats == 1 && cd_wait < cd_stall);
      #1;
      if (bus.lu_req_o) begin
        check("lu_addr", 128'(bus.lu_addr_o), 128'(addr));
        lu_pend = bus.lu_gnt_i;
      end
      if (bus.rd_req_o) begin
        check("rd_beat", 128'(bus.rd_beat_o), 128'(nbeats));
        if (bus.rd_gnt_i) rd_pend = nbeats % NB;
      end
      if (bus.upd_valid_o) nupd++;
      if (cr_held) check("cr_hold", 128'({bus.cr_valid_o, bus.cr_resp_o}), 128'({1'b1, held_resp}));
      if (bus.cr_valid_o) begin
        if (!cr_seen && !rnd_bp) check("cr_latency", 128'(k), 128'(3));
        cr_seen = 1'b1;
        if (bus.cr_ready_i) begin
          ncr++;
          check("cr_resp", 128'(bus.cr_resp_o), 128'(exp_resp));
          check("upd_at_cr", 128'(bus.upd_valid_o), 128'(e_upd));
          if (bus.upd_valid_o)
            check("upd_flags", 128'({bus.upd_inval_o, bus.upd_clean_o, bus.upd_shared_o}),
                  128'({e_inv, e_cln, e_shr}));
          cr_done = 1'b1; cr_held = 1'b0;
          if (h) m_hits++;
          if (exp_resp[0]) m_xfers++;
          if (e_inv) m_hit[idx] = 1'b0;
          if (e_cln) m_dirty[idx] = 1'b0;
          if (e_shr) m_uniq[idx] = 1'b0;
        end else begin
          cr_held = 1'b1; held_resp = bus.cr_resp_o; cr_wait++;
        end
      end
      if (cd_held) check("cd_hold", 128'({bus.cd_valid_o, bus.cd_last_o, bus.cd_data_o}),
                         128'({1'b1, held_last, held_data}));
      if (bus.cd_valid_o) begin
        if (bus.cd_ready_i) begin
          exp_data = (nbeats < NB) ? m_data[idx][nbeats] : '0;
          check("cd_order", 128'(cr_done), 128'(1));
          check("cd_data", 128'(bus.cd_data_o), 128'(exp_data));
          check("cd_last", 128'(bus.cd_last_o), 128'(nbeats == NB - 1));
          nbeats++; cd_held = 1'b0;
        end else begin
          cd_held = 1'b1; held_data = bus.cd_data_o; held_last = bus.cd_last_o; cd_wait++;
        end
      end
      if (bus.ac_ready_o) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0;
    if (!aborted) begin
      check("finished", 128'(done), 128'(1));
      check("cr_count", 128'(ncr), 128'(1));
      check("upd_count", 128'(nupd), 128'(e_upd));
      check("beat_count", 128'(nbeats), 128'(exp_beats));
    end
`ifdef ACE_SNOOP_RESP_PERF_EN
    check("perf_snoops", 128'(perf_snoops), 128'(m_snoops));
    check("perf_hits", 128'(perf_hits), 128'(m_hits));
    check("perf_data", 128'(perf_data), 128'(m_xfers));
`endif
  endtask

  initial begin
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001, 4'b1000, 4'b1101, 4'b0100, 4'b1111};
    for (int i = 0; i < NL; i++) begin
      m_hit[i] = 1'($urandom()); m_dirty[i] = 1'($urandom()); m_uniq[i] = 1'($urandom());
      for (int b = 0; b < NB; b++) m_data[i][b] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = 4'd0; bus.ac_prot_i = 3'd0;
    bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0; bus.lu_gnt_i = 1'b0; bus.lu_hit_i = 1'b0;
    bus.lu_dirty_i = 1'b0; bus.lu_unique_i = 1'b0; bus.rd_gnt_i = 1'b0; bus.rd_data_i = '0;
    do_reset();

    // Directed scenarios.
    m_hit[0] = 1'b1; m_dirty[0] = 1'b1; m_uniq[0] = 1'b1;
    run_snoop(0, 4'b0001, 0, 0, 1'b0, -1);
    m_hit[1] = 1'b0;
    run_snoop(1, 4'b0111, 0, 0, 1'b0, -1);
    m_hit[2] = 1'b1; m_dirty[2] = 1'b0; m_uniq[2] = 1'b0;
    run_snoop(2, 4'b1001, 0, 0, 1'b0, -1);
    m_hit[3] = 1'b1; m_dirty[3] = 1'b1; m_uniq[3] = 1'b1;
    run_snoop(3, 4'b0001, 5, 3, 1'b0, -1);
    m_hit[4] = 1'b1; m_dirty[4] = 1'b1; m_uniq[4] = 1'b1;
    run_snoop(4, 4'b0111, 0, 0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      check("post_reset_quiet", 128'({bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.upd_valid_o}),
            128'(4'b1000));
      @(posedge clk); #1;
    end
    m_hit[5] = 1'b1; m_dirty[5] = 1'b1; m_uniq[5] = 1'b0;
    run_snoop(5, 4'b0000, 0, 0, 1'b0, -1);
    do_reset();
    m_hit[6] = 1'b1; m_dirty[6] = 1'b1; m_uniq[6] = 1'b1;
    run_snoop(6, 4'b1111, 0, 0, 1'b0, -1);

    // Randomized snoops with random backpressure and line refills.
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = $urandom_range(0, NL - 1);
      if ($urandom_range(0, 1) == 0) begin
        m_hit[idx] = ($urandom_range(0, 3) != 0); m_dirty[idx] = 1'($urandom()); m_uniq[idx] = 1'($urandom());
      end
      run_snoop(idx, codes[$urandom_range(0, 9)], 0, 0, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
